os_array_ctrl: RTL and testbench

//  Sequencer for an output-stationary ROWS x COLS systolic array of MAC PEs.

---
 rtl/os_array_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_os_array_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/os_array_ctrl.sv
// Output-stationary systolic array sequencer: skewed operand enables,
// accumulator load/clear, and a backpressured per-column drain.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   start_valid/start_ready job handshake; cfg_k sampled at accept
//   abort                   synchronous job kill
//   row_en, col_en          skewed operand A/B enables
//   load_en, acc_clr        accumulator -> shift reg copy, accumulator zero
//   shift_en                advance drain chain (out_valid & out_ready)
//   out_valid/ready/last    drain beats, last = row 0 beat
//   busy, done              not idle; one-cycle completion pulse
module os_array_ctrl #(
   parameter int ROWS  = 4,
   parameter int COLS  = 4,
   parameter int K_MAX = 256,
   parameter int KW    = $clog2(K_MAX+1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_valid,
   output logic            start_ready,
   input  logic [KW-1:0]   cfg_k,
   input  logic            abort,
   output logic [ROWS-1:0] row_en,
   output logic [COLS-1:0] col_en,
   output logic            load_en,
   output logic            acc_clr,
   output logic            shift_en,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_last,
   output logic            busy,
   output logic            done
);

   localparam int CW_MIN = $clog2(K_MAX+ROWS+COLS+1);
   localparam int CW     = (CW_MIN > 10) ? CW_MIN : 10;
   localparam int BW     = (ROWS > 1) ? $clog2(ROWS) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_COMPUTE,
      S_LOAD,
      S_DRAIN
   } state_t;

   state_t          state_q, state_d;
   logic [KW-1:0]   k_q, k_d;
   logic [CW-1:0]   c_q, c_d;
   logic [BW-1:0]   beat_q, beat_d;
   logic [ROWS-1:0] row_en_q, row_en_d;
   logic [COLS-1:0] col_en_q, col_en_d;
   logic            load_en_q, load_en_d;
   logic            acc_clr_q, acc_clr_d;
   logic            out_valid_q, out_valid_d;
   logic            out_last_q, out_last_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            start_ready_q, start_ready_d;

   logic            accept;
   logic            kill;
   logic            beat_acc;
   logic [CW-1:0]   c_end;

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      c_d      = c_q;
      beat_d   = beat_q;
      done_d   = 1'b0;
      accept   = start_valid & (state_q == S_IDLE);
      kill     = abort & (state_q != S_IDLE);
      beat_acc = out_valid_q & out_ready;
      // Last compute cycle: skew tail lets PE(ROWS-1,COLS-1) finish.
      c_end    = CW'(k_q) + CW'(ROWS+COLS-3);

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               k_d     = (cfg_k > KW'(K_MAX)) ? KW'(K_MAX) : cfg_k;
               c_d     = '0;
               state_d = (k_d == '0) ? S_LOAD : S_COMPUTE;
            end
         end
         S_COMPUTE: begin
            if (c_q == c_end) begin
               state_d = S_LOAD;
               c_d     = '0;
            end else begin
               c_d = c_q + 1'b1;
            end
         end
         S_LOAD: begin
            state_d = S_DRAIN;
            beat_d  = '0;
         end
         S_DRAIN: begin
            if (beat_acc) begin
               if (beat_q == BW'(ROWS-1)) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
      endcase

      if (kill) begin
         state_d = S_IDLE;
         c_d     = '0;
         beat_d  = '0;
         done_d  = 1'b0;
      end

      // Outputs are registered: derive them from the next state.
      for (int r = 0; r < ROWS; r++) begin
         row_en_d[r] = (state_d == S_COMPUTE) &&
                       (c_d >= CW'(r)) &&
                       (c_d < CW'(r) + CW'(k_d));
      end
      for (int j = 0; j < COLS; j++) begin
         col_en_d[j] = (state_d == S_COMPUTE) &&
                       (c_d >= CW'(j)) &&
                       (c_d < CW'(j) + CW'(k_d));
      end
      load_en_d     = (state_d == S_LOAD);
      acc_clr_d     = (state_d == S_LOAD) | kill;
      out_valid_d   = (state_d == S_DRAIN);
      out_last_d    = (state_d == S_DRAIN) && (beat_d == BW'(ROWS-1));
      busy_d        = (state_d != S_IDLE);
      start_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         k_q           <= '0;
         c_q           <= '0;
         beat_q        <= '0;
         row_en_q      <= '0;
         col_en_q      <= '0;
         load_en_q     <= 1'b0;
         acc_clr_q     <= 1'b0;
         out_valid_q   <= 1'b0;
         out_last_q    <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         start_ready_q <= 1'b1;
      end else begin
         state_q       <= state_d;
         k_q           <= k_d;
         c_q           <= c_d;
         beat_q        <= beat_d;
         row_en_q      <= row_en_d;
         col_en_q      <= col_en_d;
         load_en_q     <= load_en_d;
         acc_clr_q     <= acc_clr_d;
         out_valid_q   <= out_valid_d;
         out_last_q    <= out_last_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         start_ready_q <= start_ready_d;
      end
   end

   assign start_ready = start_ready_q;
   assign row_en      = row_en_q;
   assign col_en      = col_en_q;
   assign load_en     = load_en_q;
   assign acc_clr     = acc_clr_q;
   assign shift_en    = out_valid_q & out_ready;
   assign out_valid   = out_valid_q;
   assign out_last    = out_last_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_os_array_ctrl.sv
// Scoreboard bench for os_array_ctrl: jobs push expected control
// traces and drain beats; a negedge monitor pops and compares.
module tb_os_array_ctrl;

   localparam int ROWS  = 4;
   localparam int COLS  = 4;
   localparam int K_MAX = 256;
   localparam int KW    = 9;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start_valid = 1'b0;
   logic            start_ready;
   logic [KW-1:0]   cfg_k = '0;
   logic            abort = 1'b0;
   logic [ROWS-1:0] row_en;
   logic [COLS-1:0] col_en;
   logic            load_en;
   logic            acc_clr;
   logic            shift_en;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic            out_last;
   logic            busy;
   logic            done;

   os_array_ctrl #(
      .ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX), .KW(KW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .start_valid(start_valid), .start_ready(start_ready),
      .cfg_k(cfg_k), .abort(abort),
      .row_en(row_en), .col_en(col_en),
      .load_en(load_en), .acc_clr(acc_clr), .shift_en(shift_en),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ROWS-1:0] row;
      logic [COLS-1:0] col;
      logic            ld;
      logic            clr;
   } tr_t;

   tr_t trace_q[$];
   bit  beat_q[$];

   int  n_chk = 0;
   int  n_pass = 0;
   int  rdy_mode = 0;
   int  rdy_cnt = 0;
   bit  mon_en = 0;
   bit  drain_armed = 0;
   bit  done_exp = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
   endtask

   function automatic int eff_k(int k);
      return (k > K_MAX) ? K_MAX : k;
   endfunction

   // Reference: operand r is live for k cycles starting at skew r;
   // compute spans k plus the array skew tail, then one load cycle,
   // then ROWS drain beats with the last flagged.
   function automatic void push_job(int k);
      int  ke;
      tr_t e;
      ke = eff_k(k);
      if (ke > 0) begin
         for (int cyc = 0; cyc < ke + ROWS + COLS - 2; cyc++) begin
            e = '0;
            for (int r = 0; r < ROWS; r++) e.row[r] = (cyc >= r) && (cyc < r + ke);
            for (int j = 0; j < COLS; j++) e.col[j] = (cyc >= j) && (cyc < j + ke);
            trace_q.push_back(e);
         end
      end
      e = '0;
      e.ld  = 1'b1;
      e.clr = 1'b1;
      trace_q.push_back(e);
      for (int i = 0; i < ROWS; i++) beat_q.push_back(i == ROWS - 1);
   endfunction

   // out_ready driver: 0 always ready, 1 random, 2 pattern 1,0,0
   initial begin
      forever begin
         @(posedge clk);
         #1;
         rdy_cnt++;
         case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = (rdy_cnt % 3 == 0);
         endcase
      end
   end

   // Monitor
   initial begin
      tr_t e;
      tr_t got;
      bit  had;
      bit  exp_busy;
      bit  l;
      forever begin
         @(negedge clk);
         if (mon_en && rst_n) begin
            got = {row_en, col_en, load_en, acc_clr};
            had = (trace_q.size() > 0);
            e   = had ? trace_q.pop_front() : tr_t'('0);
            exp_busy = (had && !(e.clr && !e.ld)) || drain_armed;
            chk("ctrl", 32'(got), 32'(e));
            chk("busy", busy, exp_busy);
            chk("start_ready", start_ready, !exp_busy);
            chk("out_valid", out_valid, drain_armed);
            chk("shift_en", shift_en, drain_armed & out_ready);
            chk("done", done, done_exp);
            done_exp = 0;
            if (drain_armed && out_valid) begin
               if (beat_q.size() == 0) begin
                  n_chk++;
                  $display("FAIL beat_queue: beat seen, none expected");
               end else begin
                  chk("out_last", out_last, beat_q[0]);
                  if (out_ready) begin
                     l = beat_q.pop_front();
                     if (l) begin
                        drain_armed = 0;
                        done_exp = 1;
                     end
                  end
               end
            end
            if (had && e.ld) drain_armed = 1;
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 of the first job cycle.
   task automatic run_job(input int k, input bit hold, input bit meas,
                          output int w, output bit d);
      bit ok;
      int n;
      int exp_lat;
      start_valid = 1'b1;
      cfg_k = KW'(k);
      ok = 0;
      w = 0;
      d = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (start_ready) begin
            ok = 1;
            w = i;
            d = done;
            break;
         end
      end
      if (!ok) begin
         n_chk++;
         $display("FAIL accept_timeout: k=%0d never accepted", k);
         start_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      push_job(k);
      if (!hold) start_valid = 1'b0;
      if (meas) begin
         exp_lat = (eff_k(k) > 0 ? eff_k(k) + ROWS + COLS - 2 : 0) + 1 + ROWS + 1;
         n = 0;
         while (n < 3000) begin
            @(negedge clk);
            n++;
            if (done) break;
         end
         chk("done_latency", n, exp_lat);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!busy && trace_q.size() == 0 && beat_q.size() == 0) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         n_chk++;
         $display("FAIL idle_timeout: busy=%0b trace=%0d beats=%0d",
                  busy, trace_q.size(), beat_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   // Abort during COMPUTE at cycle counter value 'at'.
   task automatic abort_job(input int k, input int at);
      int  w;
      bit  d;
      tr_t e;
      run_job(k, 0, 0, w, d);
      repeat (at) @(posedge clk);
      #1;
      abort = 1'b1;
      @(negedge clk);
      #1;
      trace_q.delete();
      beat_q.delete();
      e = '0;
      e.clr = 1'b1;
      trace_q.push_back(e);
      @(posedge clk);
      #1;
      abort = 1'b0;
   endtask

   initial begin
      #1_500_000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int w;
      bit d;
      int k;
      int ke;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_start_ready", start_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_row_en", row_en, 0);
      chk("rst_col_en", col_en, 0);
      chk("rst_ld_clr", {load_en, acc_clr}, 0);
      chk("rst_out", {out_valid, out_last, shift_en, done}, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      mon_en = 1;

      rdy_mode = 0;
      run_job(3, 0, 1, w, d);
      wait_idle();
      run_job(0, 0, 1, w, d);
      wait_idle();
      rdy_mode = 2;
      run_job(8, 0, 0, w, d);
      wait_idle();
      rdy_mode = 0;
      run_job(300, 0, 1, w, d);
      wait_idle();

      abort_job(5, 5);
      run_job(4, 0, 0, w, d);
      chk("accept_after_abort", w, 0);
      wait_idle();

      run_job(5, 1, 0, w, d);
      run_job(2, 0, 0, w, d);
      chk("b2b_accept_on_done", d, 1);
      wait_idle();

      for (int t = 0; t < 25; t++) begin
         rdy_mode = $urandom_range(0, 2);
         k = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 400)
                                         : $urandom_range(0, 12);
         if (k > 0 && $urandom_range(0, 3) == 0) begin
            ke = eff_k(k);
            abort_job(k, $urandom_range(0, ke + ROWS + COLS - 3));
         end else begin
            run_job(k, $urandom_range(0, 1) == 1, 0, w, d);
            start_valid = 1'b0;
         end
         if ($urandom_range(0, 1) == 1) wait_idle();
      end
      wait_idle();
      repeat (3) @(posedge clk);
      #1;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
